// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: walks the WM8731 command ROM, one I2C write per entry.
// Each entry gets a start pulse, a bounded wait for the engine's finished pulse and a bus-free gap.
module codec_init_sequencer #(
  parameter int         N_CMD          = 11,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] DEV_ADDR       = 7'h1A
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_i2c_finished,
  output logic        o_i2c_start,
  output logic [6:0]  o_addr,
  output logic        o_rw,
  output logic [15:0] o_reg_data,
  output logic        o_busy,
  output logic        o_finished,
  output logic        o_error,
  output logic [3:0]  o_index
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERR} state_t;
  state_t      r_state;
  logic [TW-1:0] r_tmo;
  logic [GW-1:0] r_gap;
  logic [3:0]  r_index;
  logic [15:0] r_reg_data;
  logic        r_start;
  logic        r_busy;
  logic        r_fin;
  logic        r_err;
  logic [3:0]  w_next_index;
  function automatic logic [15:0] rom(input logic [3:0] i);
    case (i)
      4'd0:    rom = 16'h1E00;
      4'd1:    rom = 16'h0097;
      4'd2:    rom = 16'h0297;
      4'd3:    rom = 16'h0479;
      4'd4:    rom = 16'h0679;
      4'd5:    rom = 16'h0815;
      4'd6:    rom = 16'h0A00;
      4'd7:    rom = 16'h0C00;
      4'd8:    rom = 16'h0E42;
      4'd9:    rom = 16'h1019;
      4'd10:   rom = 16'h1201;
      default: rom = 16'h0000;
    endcase
  endfunction
  assign w_next_index = r_index + 4'd1;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_gap      <= '0;
      r_index    <= 4'd0;
      r_reg_data <= rom(4'd0);
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_fin      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state    <= S_ISSUE;
            r_index    <= 4'd0;
            r_reg_data <= rom(4'd0);
            r_start    <= 1'b1;
            r_busy     <= 1'b1;
            r_fin      <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_tmo   <= '0;
        end
        S_WAIT: begin
          // a finished pulse on the last counted cycle still counts as success
          if (i_i2c_finished && r_index == 4'(N_CMD - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_fin   <= 1'b1;
          end else if (i_i2c_finished) begin
            r_state <= S_GAP;
            r_gap   <= '0;
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 2)) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_CYCLES)) begin
            r_state    <= S_ISSUE;
            r_index    <= w_next_index;
            r_reg_data <= rom(w_next_index);
            r_start    <= 1'b1;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_i2c_start = r_start;
  assign o_addr      = DEV_ADDR;
  assign o_rw        = 1'b0;
  assign o_reg_data  = r_reg_data;
  assign o_busy      = r_busy;
  assign o_finished  = r_fin;
  assign o_error     = r_err;
  assign o_index     = r_index;
endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb_codec_init_sequencer: table-driven and randomized checks of the codec init sequencer
// against a timeline model computed from start/finish/gap/timeout arithmetic.
module tb_codec_init_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, st = 1'b0, fin = 1'b0, sel = 1'b0;
  logic a_start, a_rw, a_busy, a_fin, a_err, b_start, b_rw, b_busy, b_fin, b_err;
  logic [6:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [3:0] a_idx, b_idx;
  codec_init_sequencer #(.GAP_CYCLES(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st & ~sel), .i_i2c_finished(fin & ~sel),
    .o_i2c_start(a_start), .o_addr(a_addr), .o_rw(a_rw), .o_reg_data(a_data),
    .o_busy(a_busy), .o_finished(a_fin), .o_error(a_err), .o_index(a_idx));
  codec_init_sequencer #(.GAP_CYCLES(0)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st & sel), .i_i2c_finished(fin & sel),
    .o_i2c_start(b_start), .o_addr(b_addr), .o_rw(b_rw), .o_reg_data(b_data),
    .o_busy(b_busy), .o_finished(b_fin), .o_error(b_err), .o_index(b_idx));
  logic m_start, m_rw, m_busy, m_fin, m_err;
  logic [6:0] m_addr;
  logic [15:0] m_data;
  logic [3:0] m_idx;
  assign m_start = sel ? b_start : a_start;
  assign m_rw    = sel ? b_rw : a_rw;
  assign m_busy  = sel ? b_busy : a_busy;
  assign m_fin   = sel ? b_fin : a_fin;
  assign m_err   = sel ? b_err : a_err;
  assign m_addr  = sel ? b_addr : a_addr;
  assign m_data  = sel ? b_data : a_data;
  assign m_idx   = sel ? b_idx : a_idx;

  localparam logic [15:0] ROM_T [11] = '{16'h1E00, 16'h0097, 16'h0297, 16'h0479, 16'h0679,
    16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201};
  localparam int TMO = 64;
  typedef struct {int sel; int fail_idx; int lat; int noise; int exp_fin; int exp_err; int exp_idx;} vec_t;
  int n_chk = 0, n_fail = 0;
  int s_t[11];
  int lat_v[11];
  int nstart, end_r, err_m;
  logic wait_m[2048];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline of one sequence, relative to the cycle in which i_start is driven.
  task automatic model(input int gap);
    int r = 1;
    err_m = 0;
    nstart = 0;
    for (int j = 0; j < 2048; j++) wait_m[j] = 1'b0;
    for (int k = 0; k < 11; k++) begin
      s_t[k] = r;
      nstart++;
      if (lat_v[k] >= TMO) begin
        end_r = r + TMO;
        err_m = 1;
        for (int j = r + 1; j < r + TMO; j++) wait_m[j] = 1'b1;
        break;
      end
      for (int j = r + 1; j <= r + lat_v[k]; j++) wait_m[j] = 1'b1;
      if (k == 10) end_r = r + lat_v[k] + 1;
      else r = r + lat_v[k] + gap + 2;
    end
  endtask

  task automatic run_seq(input int gap, input int noise);
    int fin_at = -1, cnt = 0, got = 0, ei, es;
    model(gap);
    for (int r = 0; r <= end_r + 2; r++) begin
      @(negedge clk);
      if (r >= 1) begin
        ei = 0;
        es = 0;
        for (int k = 0; k < nstart; k++) begin
          if (s_t[k] <= r) ei = k;
          if (s_t[k] == r) es = 1;
        end
        chk("start", 32'(m_start), 32'(es));
        chk("busy", 32'(m_busy), 32'(r < end_r));
        chk("finished", 32'(m_fin), 32'(!err_m && r >= end_r));
        chk("error", 32'(m_err), 32'(err_m && r >= end_r));
        chk("index", 32'(m_idx), 32'(ei));
        chk("reg_data", 32'(m_data), 32'(ROM_T[ei]));
        chk("addr", 32'(m_addr), 32'h1A);
        chk("rw", 32'(m_rw), 32'd0);
        if (m_start && cnt < 11) begin
          got++;
          fin_at = r + lat_v[cnt];
          cnt++;
        end
      end
      fin = (r == fin_at) || (noise != 0 && r >= 1 && !wait_m[r] && $urandom_range(0, 3) == 0);
      st = (r == 0) || (noise != 0 && r >= 1 && r < end_r && $urandom_range(0, 3) == 0);
    end
    st = 1'b0;
    fin = 1'b0;
    chk("num_starts", 32'(got), 32'(nstart));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_start"}, 32'(m_start), 32'd0);
    chk({nm, "_busy"}, 32'(m_busy), 32'd0);
    chk({nm, "_fin"}, 32'(m_fin), 32'd0);
    chk({nm, "_err"}, 32'(m_err), 32'd0);
    chk({nm, "_idx"}, 32'(m_idx), 32'd0);
    chk({nm, "_data"}, 32'(m_data), 32'h1E00);
  endtask

  vec_t vecs[7];
  initial begin
    vecs[0] = '{0, -1, 30, 0, 1, 0, 10};
    vecs[1] = '{0,  3, 30, 0, 0, 1, 3};
    vecs[2] = '{0, -1, 30, 1, 1, 0, 10};
    vecs[3] = '{1, -1, 30, 0, 1, 0, 10};
    vecs[4] = '{1, -1, 63, 0, 1, 0, 10};
    vecs[5] = '{1,  0,  1, 0, 0, 1, 0};
    vecs[6] = '{1, -1,  1, 1, 1, 0, 10};
    repeat (3) @(negedge clk);
    sel = 1'b0;
    chk_reset_vals("rst_a");
    chk("rst_a_addr", 32'(m_addr), 32'h1A);
    sel = 1'b1;
    #1 chk_reset_vals("rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    fin = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle_stray_fin");

    foreach (vecs[i]) begin
      sel = vecs[i].sel[0];
      for (int k = 0; k < 11; k++) lat_v[k] = (k == vecs[i].fail_idx) ? 999 : vecs[i].lat;
      run_seq(vecs[i].sel == 1 ? 0 : 4, vecs[i].noise);
      chk("vec_fin", 32'(m_fin), 32'(vecs[i].exp_fin));
      chk("vec_err", 32'(m_err), 32'(vecs[i].exp_err));
      chk("vec_idx", 32'(m_idx), 32'(vecs[i].exp_idx));
    end

    // Asynchronous reset while entry 5 waits for its finished pulse.
    begin
      int starts = 0, fin_at = -1, t = 0;
      sel = 1'b0;
      @(negedge clk);
      st = 1'b1;
      while (starts < 6 && t < 2000) begin
        @(negedge clk);
        t++;
        st = 1'b0;
        if (a_start) begin
          starts++;
          fin_at = t + 30;
        end
        fin = (t == fin_at) && starts < 6;
      end
      chk("pre_reset_starts", 32'(starts), 32'd6);
      repeat (10) @(negedge clk);
      chk("pre_reset_idx", 32'(m_idx), 32'd5);
      chk("pre_reset_busy", 32'(m_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset_vals("post_rst_idle");
    end

    for (int n = 0; n < 8; n++) begin
      sel = $urandom_range(0, 1) == 1;
      for (int k = 0; k < 11; k++) lat_v[k] = ($urandom_range(0, 24) == 0) ? 999 : int'($urandom_range(1, 63));
      run_seq(sel ? 0 : 4, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
